// File: rtl/rvx_core_trap_arbiter.sv
// rvx_core_trap_arbiter
// ---------------------------------------------------------------------------
// Decides each cycle whether the core takes a trap in stage 1. Prioritises
// pending stage-1 exceptions over enabled machine interrupts, forms the
// mcause value, keeps a registered copy of the last cause taken and
// sequences WFI sleep.
//
// Optional feature: define RVX_TRAP_ARBITER_IRQ_SYNC_EN to pass each irq_*
// input through a 2-flop synchroniser (adds 2 cycles of interrupt latency).
// Undefined (default): irq_* are same-domain and used directly.
//
// Ports:
//   clock, reset_n        core clock, synchronous active-low reset
//   clock_enable          global stall; sequential state holds when 0
//   current_state_s1      core state (RVX_STATE_* encodings)
//   mstatus_mie           global machine interrupt enable
//   mie_meie/mtie/msie    per-source interrupt enables
//   irq_external/timer/software  level-sensitive interrupt requests
//   misaligned_fetch_s1 .. misaligned_store_s1  stage-1 exception flags
//   wfi_s1                WFI instruction in stage 1
//   take_trap_s1          trap request to the core state machine
//   trap_cause_s1         mcause value, bit 31 = interrupt
//   last_cause            registered cause of the most recent trap taken
//   wfi_stall             core halted in WFI; fetch must stall
// ---------------------------------------------------------------------------
module rvx_core_trap_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_enable,
  input  logic [3:0]  current_state_s1,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic        mie_msie,
  input  logic        irq_external,
  input  logic        irq_timer,
  input  logic        irq_software,
  input  logic        misaligned_fetch_s1,
  input  logic        illegal_instruction_s1,
  input  logic        ebreak_s1,
  input  logic        ecall_s1,
  input  logic        misaligned_load_s1,
  input  logic        misaligned_store_s1,
  input  logic        wfi_s1,
  output logic        take_trap_s1,
  output logic [31:0] trap_cause_s1,
  output logic [31:0] last_cause,
  output logic        wfi_stall
);

  // Core state encodings, mirroring rvx_core_constants.vh.
  localparam logic [3:0] RVX_STATE_RESET      = 4'd0;
  localparam logic [3:0] RVX_STATE_OPERATING  = 4'd1;
  localparam logic [3:0] RVX_STATE_TRAP_TAKEN = 4'd2;
  localparam logic [3:0] RVX_STATE_TRAP_RET   = 4'd3;

  typedef enum logic [0:0] {
    WFI_RUN   = 1'b0,
    WFI_SLEEP = 1'b1
  } wfi_state_t;

  wfi_state_t  wfi_state_r;
  wfi_state_t  wfi_state_next_s;
  logic [2:0]  irq_s;          // {external, timer, software}
  logic [2:0]  pending_s;
  logic        any_pending_s;
  logic        int_go_s;
  logic        operating_s;
  logic        sleeping_s;
  logic        exc_any_s;
  logic [4:0]  code_s;
  logic        is_int_s;
  logic [31:0] last_cause_r;

`ifdef RVX_TRAP_ARBITER_IRQ_SYNC_EN
  logic [2:0] irq_meta_r;
  logic [2:0] irq_sync_r;

  // Two-flop synchroniser for the interrupt lines; free-running so that a
  // stalled core still sees interrupts arrive.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      irq_meta_r <= 3'b000;
      irq_sync_r <= 3'b000;
    end else begin
      irq_meta_r <= {irq_external, irq_timer, irq_software};
      irq_sync_r <= irq_meta_r;
    end
  end

  assign irq_s = irq_sync_r;
`else
  assign irq_s = {irq_external, irq_timer, irq_software};
`endif

  assign pending_s     = irq_s & {mie_meie, mie_mtie, mie_msie};
  assign any_pending_s = |pending_s;
  assign int_go_s      = mstatus_mie & any_pending_s;
  assign operating_s   = (current_state_s1 == RVX_STATE_OPERATING);
  assign sleeping_s    = (wfi_state_r == WFI_SLEEP);

  // The pipeline is stalled in SLEEP, so stage-1 exception flags are stale.
  assign exc_any_s = ~sleeping_s &
                     (misaligned_fetch_s1 | illegal_instruction_s1 | ebreak_s1 |
                      ecall_s1 | misaligned_load_s1 | misaligned_store_s1);

  // Trap arbitration: exceptions first in their fixed order, then interrupts.
  always_comb begin
    take_trap_s1 = 1'b0;
    is_int_s     = 1'b0;
    code_s       = 5'd0;
    if (operating_s && exc_any_s) begin
      take_trap_s1 = 1'b1;
      if (misaligned_fetch_s1) begin
        code_s = 5'd0;
      end else if (illegal_instruction_s1) begin
        code_s = 5'd2;
      end else if (ebreak_s1) begin
        code_s = 5'd3;
      end else if (ecall_s1) begin
        code_s = 5'd11;
      end else if (misaligned_load_s1) begin
        code_s = 5'd4;
      end else begin
        code_s = 5'd6;
      end
    end else if (operating_s && int_go_s) begin
      take_trap_s1 = 1'b1;
      is_int_s     = 1'b1;
      if (pending_s[2]) begin
        code_s = 5'd11;
      end else if (pending_s[0]) begin
        code_s = 5'd3;
      end else begin
        code_s = 5'd7;
      end
    end else begin
      take_trap_s1 = 1'b0;
    end
  end

  assign trap_cause_s1 = take_trap_s1 ? {is_int_s, 26'd0, code_s} : 32'd0;

  // Capture the cause of every trap actually taken.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_cause_r <= 32'd0;
    end else if (clock_enable && take_trap_s1) begin
      last_cause_r <= trap_cause_s1;
    end else begin
      last_cause_r <= last_cause_r;
    end
  end

  assign last_cause = last_cause_r;

  // WFI state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wfi_state_r <= WFI_RUN;
    end else if (clock_enable) begin
      wfi_state_r <= wfi_state_next_s;
    end else begin
      wfi_state_r <= wfi_state_r;
    end
  end

  // WFI next state. Wake depends on raw pending only (mstatus_mie ignored);
  // leaving OPERATING does not abandon SLEEP, only reset does.
  always_comb begin
    wfi_state_next_s = wfi_state_r;
    case (wfi_state_r)
      WFI_RUN: begin
        if (operating_s && wfi_s1 && !exc_any_s && !any_pending_s) begin
          wfi_state_next_s = WFI_SLEEP;
        end else begin
          wfi_state_next_s = WFI_RUN;
        end
      end
      WFI_SLEEP: begin
        if (any_pending_s) begin
          wfi_state_next_s = WFI_RUN;
        end else begin
          wfi_state_next_s = WFI_SLEEP;
        end
      end
      default: wfi_state_next_s = WFI_RUN;
    endcase
  end

  assign wfi_stall = (wfi_state_r == WFI_SLEEP);

endmodule

// File: tb/tb_rvx_core_trap_arbiter.sv
// Directed self-checking bench for rvx_core_trap_arbiter.
module tb_rvx_core_trap_arbiter;

  localparam logic [3:0] ST_RESET      = 4'd0;
  localparam logic [3:0] ST_OPERATING  = 4'd1;
  localparam logic [3:0] ST_TRAP_TAKEN = 4'd2;

`ifdef RVX_TRAP_ARBITER_IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clock_enable;
  logic [3:0]  current_state_s1;
  logic        mstatus_mie, mie_meie, mie_mtie, mie_msie;
  logic        irq_external, irq_timer, irq_software;
  logic        misaligned_fetch_s1, illegal_instruction_s1, ebreak_s1;
  logic        ecall_s1, misaligned_load_s1, misaligned_store_s1;
  logic        wfi_s1;
  logic        take_trap_s1;
  logic [31:0] trap_cause_s1;
  logic [31:0] last_cause;
  logic        wfi_stall;

  int n_checks = 0;
  int n_errors = 0;

  rvx_core_trap_arbiter dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .clock_enable           (clock_enable),
    .current_state_s1       (current_state_s1),
    .mstatus_mie            (mstatus_mie),
    .mie_meie               (mie_meie),
    .mie_mtie               (mie_mtie),
    .mie_msie               (mie_msie),
    .irq_external           (irq_external),
    .irq_timer              (irq_timer),
    .irq_software           (irq_software),
    .misaligned_fetch_s1    (misaligned_fetch_s1),
    .illegal_instruction_s1 (illegal_instruction_s1),
    .ebreak_s1              (ebreak_s1),
    .ecall_s1               (ecall_s1),
    .misaligned_load_s1     (misaligned_load_s1),
    .misaligned_store_s1    (misaligned_store_s1),
    .wfi_s1                 (wfi_s1),
    .take_trap_s1           (take_trap_s1),
    .trap_cause_s1          (trap_cause_s1),
    .last_cause             (last_cause),
    .wfi_stall              (wfi_stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 ns after.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_exc(input logic [5:0] v);  // {fetch,ill,ebrk,ecall,ld,st}
    {misaligned_fetch_s1, illegal_instruction_s1, ebreak_s1,
     ecall_s1, misaligned_load_s1, misaligned_store_s1} = v;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; clock_enable = 1'b1; current_state_s1 = ST_RESET;
    mstatus_mie = 1'b0; mie_meie = 1'b0; mie_mtie = 1'b0; mie_msie = 1'b0;
    irq_external = 1'b0; irq_timer = 1'b0; irq_software = 1'b0;
    wfi_s1 = 1'b0;
    set_exc(6'b000000);
    step(3);
    check("rst_take",   {31'd0, take_trap_s1}, 32'd0);
    check("rst_cause",  trap_cause_s1, 32'd0);
    check("rst_last",   last_cause, 32'd0);
    check("rst_stall",  {31'd0, wfi_stall}, 32'd0);

    // Exception beats an enabled external interrupt.
    reset_n = 1'b1; current_state_s1 = ST_OPERATING;
    irq_external = 1'b1; mie_meie = 1'b1; mstatus_mie = 1'b1;
    set_exc(6'b010000);
    step(SYNC_LAT);
    check("exc_vs_irq_take",  {31'd0, take_trap_s1}, 32'd1);
    check("exc_vs_irq_cause", trap_cause_s1, 32'h0000_0002);
    step(1);
    check("exc_last_cause", last_cause, 32'h0000_0002);

    // Exception priority order (combinational only).
    set_exc(6'b000011); check("prio_ld_st",    trap_cause_s1, 32'd4);
    set_exc(6'b000001); check("prio_st",       trap_cause_s1, 32'd6);
    set_exc(6'b000110); check("prio_ecall_ld", trap_cause_s1, 32'd11);
    set_exc(6'b001100); check("prio_ebrk_ecl", trap_cause_s1, 32'd3);
    set_exc(6'b111111); check("prio_fetch",    trap_cause_s1, 32'd0);
    check("prio_fetch_take", {31'd0, take_trap_s1}, 32'd1);
    set_exc(6'b000000);
    irq_external = 1'b0; mie_meie = 1'b0;
    step(SYNC_LAT + 1);

    // Interrupt priority: software over timer.
    irq_timer = 1'b1; irq_software = 1'b1; mie_mtie = 1'b1; mie_msie = 1'b1;
    step(SYNC_LAT); #1;
    check("int_sw_cause", trap_cause_s1, 32'h8000_0003);
    irq_software = 1'b0;
    step(SYNC_LAT); #1;
    check("int_tmr_cause", trap_cause_s1, 32'h8000_0007);
    mstatus_mie = 1'b0; #1;
    check("int_masked_take", {31'd0, take_trap_s1}, 32'd0);

    // Non-operating state suppresses everything.
    mstatus_mie = 1'b1; current_state_s1 = ST_TRAP_TAKEN;
    set_exc(6'b000100);
    check("trap_taken_take",  {31'd0, take_trap_s1}, 32'd0);
    check("trap_taken_cause", trap_cause_s1, 32'd0);
    set_exc(6'b000000);
    current_state_s1 = ST_OPERATING;
    irq_timer = 1'b0; mstatus_mie = 1'b0;
    step(SYNC_LAT + 1);

    // WFI with nothing pending sleeps; timer wakes it without a trap.
    wfi_s1 = 1'b1;
    step(1);
    check("wfi_sleep", {31'd0, wfi_stall}, 32'd1);
    wfi_s1 = 1'b0;
    set_exc(6'b010000);
    check("sleep_exc_ignored", {31'd0, take_trap_s1}, 32'd0);
    set_exc(6'b000000);
    irq_timer = 1'b1;
    step(SYNC_LAT); #1;
    check("wake_edge_stall", {31'd0, wfi_stall}, 32'd1);
    check("wake_edge_take",  {31'd0, take_trap_s1}, 32'd0);
    step(1);
    check("woken_stall", {31'd0, wfi_stall}, 32'd0);
    check("woken_take",  {31'd0, take_trap_s1}, 32'd0);
    irq_timer = 1'b0;
    step(SYNC_LAT + 1);

    // Sleep again; external interrupt with mie set traps in the wake cycle.
    wfi_s1 = 1'b1;
    step(1);
    check("wfi_sleep2", {31'd0, wfi_stall}, 32'd1);
    wfi_s1 = 1'b0;
    irq_external = 1'b1; mie_meie = 1'b1; mstatus_mie = 1'b1;
    step(SYNC_LAT); #1;
    check("wake_trap_take",  {31'd0, take_trap_s1}, 32'd1);
    check("wake_trap_cause", trap_cause_s1, 32'h8000_000B);
    check("wake_trap_stall", {31'd0, wfi_stall}, 32'd1);
    step(1);
    check("wake_trap_last",  last_cause, 32'h8000_000B);
    check("wake_trap_stall2", {31'd0, wfi_stall}, 32'd0);
    irq_external = 1'b0; mie_meie = 1'b0;
    step(SYNC_LAT + 1);

    // Stalled trap cycle does not update last_cause.
    clock_enable = 1'b0;
    set_exc(6'b010000);
    check("ce0_take", {31'd0, take_trap_s1}, 32'd1);
    step(1);
    check("ce0_last_hold", last_cause, 32'h8000_000B);
    set_exc(6'b000000);
    clock_enable = 1'b1;

    // Reset while sleeping.
    wfi_s1 = 1'b1;
    step(1);
    check("wfi_sleep3", {31'd0, wfi_stall}, 32'd1);
    wfi_s1 = 1'b0;
    reset_n = 1'b0; current_state_s1 = ST_RESET;
    step(1);
    check("rst_sleep_stall", {31'd0, wfi_stall}, 32'd0);
    check("rst_sleep_last",  last_cause, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rvx_core_trap_arbiter.md
Name: rvx_core_trap_arbiter

Overview:
- Decides, each cycle, whether the core takes a trap in stage 1.
- Prioritises pending exceptions and enabled machine interrupts, produces the mcause value, and sequences WFI sleep.
- Drives take_trap_s1 into the core state machine and consumes that machine's current_state_s1.
- Sits between the decoder/LSU exception sources, the CSR file and the core state register.

Parameters:
- none (state encodings come from rvx_core_constants.vh).

Ports:
- clock  input  1  core clock
- reset_n  input  1  synchronous active-low reset
- clock_enable  input  1  global stall; sequential state holds when 0
- current_state_s1  input  4  core state (RVX_STATE_* encodings)
- mstatus_mie  input  1  global machine interrupt enable
- mie_meie, mie_mtie, mie_msie  input  1 each  per-source interrupt enables
- irq_external, irq_timer, irq_software  input  1 each  level-sensitive interrupt requests
- misaligned_fetch_s1, illegal_instruction_s1, ebreak_s1, ecall_s1, misaligned_load_s1, misaligned_store_s1  input  1 each  stage-1 exception flags
- wfi_s1  input  1  WFI instruction in stage 1
- take_trap_s1  output  1  trap request to state machine
- trap_cause_s1  output  32  mcause value; bit 31 = interrupt
- last_cause  output  32  registered cause of the most recent trap taken
- wfi_stall  output  1  core halted in WFI; fetch must stall

Behaviour:
- Reset, synchronous on reset_n=0:
  - wfi FSM goes to RUN; last_cause=0; wfi_stall=0.
  - take_trap_s1=0, because current_state_s1 is RESET.
- Arbitration is purely combinational. It is evaluated only when current_state_s1==RVX_STATE_OPERATING; in any other state take_trap_s1=0 and trap_cause_s1=0.
- Masked interrupt pending, per source: p_x = irq_x & mie_x, using the synchronised irq when the optional feature is enabled.
- Interrupt taken: int_go = mstatus_mie & (p_e|p_t|p_s).
- Exception priority, highest first, with cause codes:
  - misaligned_fetch 0
  - illegal 2
  - ebreak 3
  - ecall 11
  - misaligned_load 4
  - misaligned_store 6
- Interrupt priority: external 11 > software 3 > timer 7. trap_cause_s1 = {1'b1, 26'b0, code} for interrupts and {1'b0, 26'b0, code} for exceptions.
- Any exception beats any interrupt in the same cycle.
- take_trap_s1 = OPERATING & (any exception | int_go).
- last_cause loads trap_cause_s1 on clock_enable & take_trap_s1, otherwise holds. No latency beyond this one register.
- WFI FSM, advancing only when clock_enable=1:
  - RUN: if OPERATING & wfi_s1 & no exception & no raw pending (p_e|p_t|p_s)=0, go to SLEEP.
  - If wfi_s1 and a pending interrupt coexist, stay in RUN. WFI retires as a NOP, and takes a trap if int_go.
  - SLEEP: wfi_stall=1. When (p_e|p_t|p_s)=1, go to RUN. Wake ignores mstatus_mie, per the privileged spec.
  - SLEEP with int_go=1 also asserts take_trap_s1 in the wake cycle, giving a 1-cycle wake-to-trap.
  - SLEEP with int_go=0 leaves wfi_stall=0 next cycle and execution resumes after WFI.
  - The exit transition is combinational on pending, so the cycle pending rises still shows wfi_stall=1 and the next shows 0.
- wfi_stall is a registered output (FSM==SLEEP).
- While in SLEEP, exception inputs are ignored, since the pipeline is stalled.
- If current_state_s1 leaves OPERATING while in SLEEP (e.g. reset), SLEEP is abandoned on reset only.
- clock_enable=0 freezes the FSM and last_cause. Combinational outputs still track inputs.
- Mid-operation reset returns to RUN in one cycle regardless of pending IRQs.

Optional Feature:
- Macro: RVX_TRAP_ARBITER_IRQ_SYNC_EN.
- Defined: each irq_* input passes through a 2-flop synchroniser clocked by clock. The flops are cleared by reset and ignore clock_enable. This adds 2 cycles of interrupt latency.
- Undefined: irq_* are used directly (same clock domain); zero added latency.

Test Plan:
- OPERATING, illegal_instruction_s1=1 and irq_external=1, mie_meie=1, mstatus_mie=1 -> take_trap_s1=1, trap_cause_s1=0x00000002; last_cause=0x2 next cycle.
- OPERATING, irq_timer=irq_software=1, both enabled, mstatus_mie=1 -> trap_cause_s1=0x80000003. Drop software -> 0x80000007.
- current_state_s1=RVX_STATE_TRAP_TAKEN, ecall_s1=1 -> take_trap_s1=0, trap_cause_s1=0.
- wfi_s1=1, no pending -> wfi_stall=1 next cycle. Raise irq_timer with mie_mtie=1, mstatus_mie=0 -> wfi_stall=0 one cycle later, take_trap_s1 never asserts.
- SLEEP, raise irq_external with meie=1, mie=1 -> take_trap_s1=1 with cause 0x8000000B in the wake cycle. With SYNC_EN defined, assertion is 2 cycles later.
- clock_enable=0 during a trap cycle -> last_cause unchanged. Then reset_n=0 while in SLEEP -> wfi_stall=0 and last_cause=0 after one edge.
